imem_loader: RTL and testbench

Boot-time loader that sits directly upstream of the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready handshake and packs it into big-endian 32-bit words. Each word is written into instruction memory. While loading, the core is held in reset; `cpu_nrst` is released only after the checksum verifies.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CSUM_W         = 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte packer: the word is presented combinationally alongside
// the byte that completes it, so the owner can register it in one step.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_valid = en && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift_q, din};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (en) begin
      shift_q <= {shift_q[15:0], din};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into IMEM and holds the
// core in reset until the checksum verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        reload,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_nrst,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned IDX_W     = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  state_t            state;
  logic [7:0]        n_hi;
  logic [IDX_W-1:0]  n_words;
  logic [IDX_W-1:0]  word_idx;
  logic [CSUM_W-1:0] csum;
  logic [15:0]       n_full;
  logic              xfer;
  logic              pk_clr;
  logic              pk_valid;
  logic [31:0]       pk_word;

  assign in_ready = (state inside {HDR_HI, HDR_LO, LOAD, CHECK});
  assign xfer     = in_valid && in_ready;
  assign n_full   = {n_hi, in_data};
  // Packer is flushed per frame so a frame can never inherit a partial word.
  assign pk_clr   = (state == HDR_LO) || ((state inside {DONE, ERROR}) && reload);

  byte_packer u_packer (
    .clk        (clk),
    .nrst       (nrst),
    .clr        (pk_clr),
    .en         (xfer && (state == LOAD)),
    .din        (in_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= HDR_HI;
      n_hi       <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_nrst   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR_HI: if (xfer) begin
          n_hi  <= in_data;
          state <= HDR_LO;
        end
        HDR_LO: if (xfer) begin
          if (32'(n_full) > MAX_WORDS) begin
            state      <= ERROR;
            load_error <= 1'b1;
          end else if (n_full == '0) begin
            state <= CHECK;
          end else begin
            n_words <= IDX_W'(n_full);
            state   <= LOAD;
          end
        end
        LOAD: if (xfer) begin
          csum <= csum ^ in_data;
          if (pk_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= 32'(word_idx) << 2;
            imem_wdata <= pk_word;
            word_idx   <= word_idx + IDX_ONE;
            if (word_idx + IDX_ONE == n_words) state <= CHECK;
          end
        end
        CHECK: if (xfer) begin
          if (in_data == csum) begin
            state     <= DONE;
            load_done <= 1'b1;
            cpu_nrst  <= 1'b1;
          end else begin
            state      <= ERROR;
            load_error <= 1'b1;
          end
        end
        DONE, ERROR: if (reload) begin
          state      <= HDR_HI;
          n_hi       <= '0;
          n_words    <= '0;
          word_idx   <= '0;
          csum       <= '0;
          cpu_nrst   <= 1'b0;
          load_done  <= 1'b0;
          load_error <= 1'b0;
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus hand-written corner
// sequences, with IMEM writes checked against a queue of expected words.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        reload = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_nrst;
  logic        load_done;
  logic        load_error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [0:11][7:0] bytes;
    int unsigned      len;
    logic             exp_done;
    logic             exp_err;
    int unsigned      exp_writes;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  wr_t         exp_q [$];
  wr_t         mon_e;
  int unsigned wr_count = 0;
  logic [31:0] last_addr = '0;
  logic        prev_we = 1'b0;

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .reload     (reload),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_nrst   (cpu_nrst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst && imem_we) begin
      wr_count++;
      last_addr = imem_addr;
      check("we_pulse_len", {31'b0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write act=%0h exp=none", imem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e.addr);
        check("wr_data", imem_wdata, mon_e.data);
      end
    end
    prev_we = nrst && imem_we;
  end

  task automatic do_reset();
    nrst = 1'b0;
    in_valid = 1'b0;
    reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    wr_count = 0;
    nrst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned guard;
    in_valid = 1'b0;
    for (int unsigned g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    guard = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    int          p;

    vecs[0] = '{bytes: {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D, 40'h0},
                len: 7, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vecs[1] = '{bytes: {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C, 40'h0},
                len: 7, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 1};
    vecs[2] = '{bytes: {8'h01, 8'h01, 80'h0},
                len: 2, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[3] = '{bytes: {8'h00, 8'h00, 8'h00, 72'h0},
                len: 3, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0};
    vecs[4] = '{bytes: {8'h00, 8'h00, 8'hFF, 72'h0},
                len: 3, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[5] = '{bytes: {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                        8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44, 8'h00},
                len: 11, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2};
    vecs[6] = '{bytes: {8'h10, 8'h00, 80'h0},
                len: 2, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};

    // Reset values while nrst is held low
    #1;
    check("rst_we", {31'b0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_nrst", {31'b0, cpu_nrst}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_err", {31'b0, load_error}, 32'd0);
    do_reset();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      w = '0;
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        b = vecs[v].bytes[i];
        if (i >= 2 && i < 2 + 4 * int'(vecs[v].exp_writes)) begin
          p = i - 2;
          w = {w[23:0], b};
          if (p % 4 == 3) exp_q.push_back('{addr: 32'((p / 4) * 4), data: w});
        end
        send_byte(b, 0);
      end
      check($sformatf("v%0d_done", v), {31'b0, load_done}, {31'b0, vecs[v].exp_done});
      check($sformatf("v%0d_err", v), {31'b0, load_error}, {31'b0, vecs[v].exp_err});
      check($sformatf("v%0d_cpu_nrst", v), {31'b0, cpu_nrst}, {31'b0, vecs[v].exp_done});
      check($sformatf("v%0d_in_ready", v), {31'b0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_wr_count", v), wr_count, vecs[v].exp_writes);
      check($sformatf("v%0d_q_empty", v), exp_q.size(), 32'd0);
    end

    // Full capacity with random source gaps
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back('{addr: 32'(k * 4), data: 32'(k)});
      send_byte(8'h00, $urandom_range(0, 2));
      send_byte(8'h00, $urandom_range(0, 2));
      send_byte(8'h00, $urandom_range(0, 2));
      send_byte(8'(k), $urandom_range(0, 2));
    end
    send_byte(8'h00, $urandom_range(0, 2));
    check("full_done", {31'b0, load_done}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("full_wr_count", wr_count, 32'd256);
    check("full_last_addr", last_addr, 32'h3FC);
    check("full_q_empty", exp_q.size(), 32'd0);

    // Reset asserted after two words of a four-word frame
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    exp_q.push_back('{addr: 32'h0, data: 32'hA0A1A2A3});
    exp_q.push_back('{addr: 32'h4, data: 32'hB0B1B2B3});
    send_byte(8'hA0, 0); send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0);
    send_byte(8'hB0, 0); send_byte(8'hB1, 0); send_byte(8'hB2, 0); send_byte(8'hB3, 0);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("mid_rst_we", {31'b0, imem_we}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_cpu_nrst", {31'b0, cpu_nrst}, 32'd0);
    check("mid_rst_done", {31'b0, load_done}, 32'd0);
    check("mid_rst_wr_count", wr_count, 32'd2);
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'hCAFEBABE});
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hCA, 0); send_byte(8'hFE, 0); send_byte(8'hBA, 0); send_byte(8'hBE, 0);
    check("lat_we_hi", {31'b0, imem_we}, 32'd1);
    check("lat_addr", imem_addr, 32'd0);
    @(posedge clk);
    #1;
    check("lat_we_lo", {31'b0, imem_we}, 32'd0);
    check("lat_done_pending", {31'b0, load_done}, 32'd0);
    send_byte(8'h30, 0);
    check("fresh_done", {31'b0, load_done}, 32'd1);
    check("fresh_cpu_nrst", {31'b0, cpu_nrst}, 32'd1);

    // Reload from DONE, then a second frame with a stray mid-load reload
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_cpu_nrst", {31'b0, cpu_nrst}, 32'd0);
    check("reload_done", {31'b0, load_done}, 32'd0);
    check("reload_in_ready", {31'b0, in_ready}, 32'd1);
    wr_count = 0;
    exp_q.push_back('{addr: 32'h0, data: 32'h01020304});
    exp_q.push_back('{addr: 32'h4, data: 32'h05060708});
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    send_byte(8'h04, 0);
    send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
    send_byte(8'h08, 0);
    check("reload2_done", {31'b0, load_done}, 32'd1);
    check("reload2_err", {31'b0, load_error}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reload2_wr_count", wr_count, 32'd2);
    check("reload2_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
